lcd12864_bus_sink: RTL and testbench
====================================

// Module: lcd12864_bus_sink
// PURPOSE
// - Receiving end of the ST7920-style 128x64 LCD 8-bit parallel write bus (rs/rw/en/dat).
// - Decodes instructions and GDRAM writes as a panel would; mirrors the 1 KB graphic RAM for readback.
// - On-chip display model: a loopback target for the LCD driver and a frame-capture point for benches.
// PARAMETERS
// - SYNC_STAGES  2   synchroniser depth on lcd_en, lcd_rs, lcd_rw and lcd_dat (>=2)
// - V_ROWS       32  GDRAM vertical addresses stored (0..V_ROWS-1)
// - H_WORDS      16  16-bit words per vertical address (horizontal 0..H_WORDS-1)
// PORTS
// - clk           in   1   system clock, 50 MHz, >=8x the lcd_en toggle rate
// - rst_n         in   1   asynchronous active-low reset
// - lcd_rs        in   1   0 = instruction, 1 = data
// - lcd_rw        in   1   0 = write; 1 = read (unsupported, flagged)
// - lcd_en        in   1   bus strobe; transfer latched on its falling edge
// - lcd_dat       in   8   bus data
// - rd_addr       in   9   readback word address {v[4:0],h[3:0]}
// - rd_data       out  16  readback word {first byte, second byte}; 1-cycle latency
// - re_mode       out  1   extended instruction set active
// - graphic_on    out  1   graphic display enabled
// - display_on    out  1   display enabled (D bit)
// - word_wr       out  1   1-cycle pulse when a GDRAM word commits
// - wr_v / wr_h   out  5/4 address of the committed word, valid with word_wr
// - frame_done    out  1   1-cycle pulse when word (V_ROWS-1, H_WORDS-1) commits
// - proto_err     out  1   1-cycle pulse on any protocol violation below
// BEHAVIOUR
// - Reset: all outputs 0; RE=0, G=0, D=0; v=h=0; addr phase and byte phase cleared. RAM contents undefined.
// - Sampling: inputs pass SYNC_STAGES flops; strobe = synced en 1->0; rs/rw/dat taken from the same stage.
// - Status and pulse outputs update 1 clk after strobe; RAM write happens in the strobe cycle.
// - rw=1 on strobe: ignored, proto_err.
// - Instruction (rs=0), 0x30-0x3F function set: RE<=dat[2]; G<=dat[1] only when RE already 1
//   (0x36 sent twice: first write sets RE, second sets G).
// - RE=0: 0x08-0x0F sets D=dat[2]; 0x01 clears RAM state: v=h=0, phases cleared, RAM untouched.
// - RE=1: 0x01 is standby, no state change.
// - RE=1, dat[7]=1: GDRAM address. Phase 0 -> v<=dat[6:0] (latch); phase 1 -> h<=dat[3:0].
//   Phase toggles per address write and the byte phase clears.
// - Vertical value >= V_ROWS: proto_err; subsequent data writes discarded until a valid v is set.
// - Other opcodes: accepted silently; any other instruction while addr phase=1 -> phase 0, proto_err.
// - Data (rs=1): only legal with RE=1, G=1, addr phase 0; otherwise discarded + proto_err.
//   Byte phase 0: hold byte in hi register. Byte phase 1: write {hi,dat} at {v,h}, then word_wr.
//   h<=h+1, wrapping H_WORDS-1 -> 0 with v unchanged.
// - Instruction between the two data bytes: the held byte is dropped, proto_err, byte phase 0.
// - Readback: rd_data = RAM[rd_addr], registered; same-cycle write to same address returns old word.
// - Reset mid-transfer: everything above resets at once; the first strobe after release decodes normally.
// STRUCTURE
// - lcd12864_defs.vh (shared with the driver): opcode constants SET_MODE_8BIT=0x30,
//   SET_MODE_GRAPHIC=0x36, DISPLAY_ON=0x0C, CLEAR_STANDBY=0x01, GDRAM address base 0x80.
// - Sub-module lcd_bus_sampler: synchroniser + falling-edge strobe + aligned rs/rw/dat capture.
// - Top level: decode FSM (IDLE, ADDR_H, DATA_LO), address/byte registers, 512x16 RAM inferred.
// TESTING
// - Write 0x30,0x0C,0x36,0x36 -> display_on=1, re_mode=1, graphic_on=1; no proto_err.
// - Write 0x80,0x80,0xAA,0x55 -> word_wr with v=0, h=0; rd_addr=0 gives 0xAA55.
// - Set v=3,h=15; write two byte pairs -> words at (3,15) and (3,0); v remains 3.
// - Full driver sequence over 32x16 words -> frame_done once; RAM matches source image byte-for-byte.
// - Faults: data with G=0 -> proto_err, RAM unchanged; 0x80 then 0xAA -> proto_err, phase 0;
//   v=0xA0 -> proto_err and following data is dropped.
// - Assert rst_n after one data byte -> next pair writes (0,0) cleanly; 0x01 with RE=1 -> v,h unchanged.

Source files
------------

// File: rtl/lcd12864_bus_sink_pkg.sv
// Shared opcode constants, field widths and decode helpers for the 128x64 LCD bus sink.
// The opcode values match the ones the LCD driver emits.
package lcd12864_bus_sink_pkg;

    localparam logic [7:0] SET_MODE_8BIT    = 8'h30;
    localparam logic [7:0] SET_MODE_GRAPHIC = 8'h36;
    localparam logic [7:0] DISPLAY_ON       = 8'h0C;
    localparam logic [7:0] CLEAR_STANDBY    = 8'h01;
    localparam logic [7:0] GDRAM_ADDR_BASE  = 8'h80;

    localparam int V_W = 5;
    localparam int H_W = 4;

    // IDLE: both phases clear; ADDR_H: vertical latched, horizontal next; DATA_LO: high byte held
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR_H  = 2'd1,
        ST_DATA_LO = 2'd2
    } sink_state_e;

    function automatic logic is_func_set(input logic [7:0] op);
        return op[7:4] == SET_MODE_8BIT[7:4];
    endfunction

    function automatic logic is_display_ctl(input logic [7:0] op);
        return op[7:3] == DISPLAY_ON[7:3];
    endfunction

    function automatic logic is_gdram_addr(input logic [7:0] op);
        return (op & GDRAM_ADDR_BASE) != 8'h00;
    endfunction

endpackage

// File: rtl/lcd12864_bus_sink_if.sv
// ST7920-style 8-bit parallel write bus: the driver owns every wire, the sink only listens.
interface lcd12864_bus_sink_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_dat;

    modport master (output lcd_rs, lcd_rw, lcd_en, lcd_dat);
    modport slave  (input  lcd_rs, lcd_rw, lcd_en, lcd_dat);
endinterface

// File: rtl/lcd12864_bus_sink_sampler.sv
// Synchronises the asynchronous LCD bus and emits a one-cycle strobe on the falling edge of en,
// with rs/rw/dat presented from the same synchroniser stage as the edge.
module lcd_bus_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd12864_bus_sink_if.slave   bus,
    output logic                 strobe,
    output logic                 s_rs,
    output logic                 s_rw,
    output logic [7:0]           s_dat
);

    // Packed as {en, rs, rw, dat[7:0]} so all four fields age together
    logic [10:0] sync_reg [SYNC_STAGES];
    logic        en_last_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_reg[gi] <= '0;
                    end else begin
                        sync_reg[gi] <= {bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_dat};
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_reg[gi] <= '0;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_last_reg <= 1'b0;
        end else begin
            en_last_reg <= sync_reg[SYNC_STAGES-1][10];
        end
    end

    assign strobe = en_last_reg & ~sync_reg[SYNC_STAGES-1][10];
    assign s_rs   = sync_reg[SYNC_STAGES-1][9];
    assign s_rw   = sync_reg[SYNC_STAGES-1][8];
    assign s_dat  = sync_reg[SYNC_STAGES-1][7:0];

endmodule

// File: rtl/lcd12864_bus_sink.sv
// Panel-side model of a 128x64 LCD write bus: decodes instructions and GDRAM writes,
// mirrors the graphic RAM for readback and reports protocol violations.
module lcd12864_bus_sink
    import lcd12864_bus_sink_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int V_ROWS      = 32,
    parameter int H_WORDS     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd12864_bus_sink_if.slave   bus,
    input  logic [8:0]           rd_addr,
    output logic [15:0]          rd_data,
    output logic                 re_mode,
    output logic                 graphic_on,
    output logic                 display_on,
    output logic                 word_wr,
    output logic [V_W-1:0]       wr_v,
    output logic [H_W-1:0]       wr_h,
    output logic                 frame_done,
    output logic                 proto_err
);

    localparam int           DEPTH   = V_ROWS * H_WORDS;
    localparam logic [6:0]   V_LIMIT = 7'(V_ROWS);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_ROWS - 1);
    localparam logic [H_W-1:0] H_LAST = H_W'(H_WORDS - 1);

    logic       strobe;
    logic       s_rs;
    logic       s_rw;
    logic [7:0] s_dat;

    lcd_bus_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .strobe (strobe),
        .s_rs   (s_rs),
        .s_rw   (s_rw),
        .s_dat  (s_dat)
    );

    sink_state_e    state_reg, state_next;
    logic           re_reg, re_next;
    logic           g_reg, g_next;
    logic           d_reg, d_next;
    logic [V_W-1:0] v_reg, v_next;
    logic           v_valid_reg, v_valid_next;
    logic [H_W-1:0] h_reg, h_next;
    logic [7:0]     hi_reg, hi_next;
    logic           word_wr_reg, word_wr_next;
    logic [V_W-1:0] wr_v_reg, wr_v_next;
    logic [H_W-1:0] wr_h_reg, wr_h_next;
    logic           frame_done_reg, frame_done_next;
    logic           proto_err_reg, proto_err_next;
    logic           ram_we;
    logic           is_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            re_reg         <= 1'b0;
            g_reg          <= 1'b0;
            d_reg          <= 1'b0;
            v_reg          <= '0;
            v_valid_reg    <= 1'b1;
            h_reg          <= '0;
            hi_reg         <= '0;
            word_wr_reg    <= 1'b0;
            wr_v_reg       <= '0;
            wr_h_reg       <= '0;
            frame_done_reg <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            re_reg         <= re_next;
            g_reg          <= g_next;
            d_reg          <= d_next;
            v_reg          <= v_next;
            v_valid_reg    <= v_valid_next;
            h_reg          <= h_next;
            hi_reg         <= hi_next;
            word_wr_reg    <= word_wr_next;
            wr_v_reg       <= wr_v_next;
            wr_h_reg       <= wr_h_next;
            frame_done_reg <= frame_done_next;
            proto_err_reg  <= proto_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        re_next         = re_reg;
        g_next          = g_reg;
        d_next          = d_reg;
        v_next          = v_reg;
        v_valid_next    = v_valid_reg;
        h_next          = h_reg;
        hi_next         = hi_reg;
        word_wr_next    = 1'b0;
        wr_v_next       = wr_v_reg;
        wr_h_next       = wr_h_reg;
        frame_done_next = 1'b0;
        proto_err_next  = 1'b0;
        ram_we          = 1'b0;
        is_addr         = re_reg && is_gdram_addr(s_dat);

        if (strobe) begin
            if (s_rw) begin
                proto_err_next = 1'b1;
            end else if (!s_rs) begin
                // Any instruction drops a half-written word; a non-address one also breaks an address pair
                if (state_reg == ST_DATA_LO || (state_reg == ST_ADDR_H && !is_addr)) begin
                    proto_err_next = 1'b1;
                end
                state_next = ST_IDLE;
                if (is_addr) begin
                    if (state_reg == ST_ADDR_H) begin
                        h_next = s_dat[H_W-1:0];
                    end else begin
                        v_next       = s_dat[V_W-1:0];
                        v_valid_next = s_dat[6:0] < V_LIMIT;
                        if (s_dat[6:0] >= V_LIMIT) begin
                            proto_err_next = 1'b1;
                        end
                        state_next = ST_ADDR_H;
                    end
                end else if (is_func_set(s_dat)) begin
                    re_next = s_dat[2];
                    if (re_reg) begin
                        g_next = s_dat[1];
                    end
                end else if (!re_reg && is_display_ctl(s_dat)) begin
                    d_next = s_dat[2];
                end else if (!re_reg && s_dat == CLEAR_STANDBY) begin
                    v_next       = '0;
                    v_valid_next = 1'b1;
                    h_next       = '0;
                end
            end else begin
                if (!re_reg || !g_reg || state_reg == ST_ADDR_H || !v_valid_reg) begin
                    proto_err_next = 1'b1;
                    state_next     = ST_IDLE;
                end else if (state_reg == ST_IDLE) begin
                    hi_next    = s_dat;
                    state_next = ST_DATA_LO;
                end else begin
                    ram_we          = 1'b1;
                    word_wr_next    = 1'b1;
                    wr_v_next       = v_reg;
                    wr_h_next       = h_reg;
                    frame_done_next = (v_reg == V_LAST) && (h_reg == H_LAST);
                    h_next          = (h_reg == H_LAST) ? '0 : h_reg + H_W'(1);
                    state_next      = ST_IDLE;
                end
            end
        end
    end

    // Graphic RAM mirror; read and write in separate processes so a colliding read sees the old word
    logic [15:0] mem [0:DEPTH-1];
    logic [15:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[{v_reg, h_reg}] <= {hi_reg, s_dat};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data    = rd_data_reg;
    assign re_mode    = re_reg;
    assign graphic_on = g_reg;
    assign display_on = d_reg;
    assign word_wr    = word_wr_reg;
    assign wr_v       = wr_v_reg;
    assign wr_h       = wr_h_reg;
    assign frame_done = frame_done_reg;
    assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_lcd12864_bus_sink.sv
// Directed bench for lcd12864_bus_sink: drives the LCD bus like the driver and checks
// decoded state, pulse counts and the RAM mirror against hand-computed values.
module tb_lcd12864_bus_sink;
    import lcd12864_bus_sink_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        re_mode, graphic_on, display_on, word_wr, frame_done, proto_err;
    logic [4:0]  wr_v;
    logic [3:0]  wr_h;

    lcd12864_bus_sink_if bus_if ();

    lcd12864_bus_sink dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .re_mode    (re_mode),
        .graphic_on (graphic_on),
        .display_on (display_on),
        .word_wr    (word_wr),
        .wr_v       (wr_v),
        .wr_h       (wr_h),
        .frame_done (frame_done),
        .proto_err  (proto_err)
    );

    always #10 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int wr_cnt = 0, err_cnt = 0, frame_cnt = 0;
    logic [4:0] last_v = '0;
    logic [3:0] last_h = '0;

    always @(negedge clk) begin
        if (word_wr) begin
            wr_cnt = wr_cnt + 1;
            last_v = wr_v;
            last_h = wr_h;
        end
        if (proto_err)  err_cnt   = err_cnt + 1;
        if (frame_done) frame_cnt = frame_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic bus_wr(input logic rs, input logic rw, input logic [7:0] dat);
        @(negedge clk);
        bus_if.lcd_rs  = rs;
        bus_if.lcd_rw  = rw;
        bus_if.lcd_dat = dat;
        repeat (2) @(negedge clk);
        bus_if.lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.lcd_en = 1'b0;
        repeat (8) @(negedge clk);
        $display("bus rs=%0d rw=%0d dat=0x%02h", rs, rw, dat);
    endtask

    task automatic ins(input logic [7:0] op);
        bus_wr(1'b0, 1'b0, op);
    endtask

    task automatic dat_pair(input logic [7:0] hi, input logic [7:0] lo);
        bus_wr(1'b1, 1'b0, hi);
        bus_wr(1'b1, 1'b0, lo);
    endtask

    task automatic rd_word(input logic [8:0] a, output logic [15:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
        $display("read addr=%0d data=0x%04h", a, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.lcd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {26'd0, re_mode, graphic_on, display_on, word_wr, frame_done, proto_err}, 32'd0);
        chk("rst_wr_addr", {23'd0, wr_v, wr_h}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [15:0] img(input int v, input int h);
        logic [7:0] a, b;
        a = 8'((v * 16 + h) * 7) ^ 8'h5A;
        b = ~8'(v + h * 3);
        return {a, b};
    endfunction

    initial begin
        int e0, w0, f0;
        logic [15:0] d;

        bus_if.lcd_rs  = 1'b0;
        bus_if.lcd_rw  = 1'b0;
        bus_if.lcd_en  = 1'b0;
        bus_if.lcd_dat = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Init: function set, display on, extended set, graphic on
        e0 = err_cnt;
        ins(SET_MODE_8BIT);
        ins(DISPLAY_ON);
        chk("disp_on", {31'd0, display_on}, 32'd1);
        ins(SET_MODE_GRAPHIC);
        chk("re_after_first_36", {30'd0, re_mode, graphic_on}, 32'b10);
        ins(SET_MODE_GRAPHIC);
        chk("re_g_after_second_36", {30'd0, re_mode, graphic_on}, 32'b11);
        chk("init_no_err", err_cnt - e0, 0);

        // Read strobe is flagged and otherwise ignored
        e0 = err_cnt;
        bus_wr(1'b0, 1'b1, 8'h08);
        chk("rw1_err", err_cnt - e0, 1);
        chk("rw1_no_effect", {31'd0, display_on}, 32'd1);

        // First word at (0,0)
        w0 = wr_cnt; e0 = err_cnt;
        ins(8'h80); ins(8'h80);
        dat_pair(8'hAA, 8'h55);
        chk("w00_count", wr_cnt - w0, 1);
        chk("w00_addr", {last_v, last_h}, 9'd0);
        rd_word(9'd0, d);
        chk("w00_data", d, 16'hAA55);
        chk("w00_no_err", err_cnt - e0, 0);

        // Horizontal wrap at (3,15) -> (3,0)
        ins(8'h83); ins(8'h8F);
        dat_pair(8'h12, 8'h34);
        chk("wrap_first", {last_v, last_h}, {5'd3, 4'd15});
        dat_pair(8'h56, 8'h78);
        chk("wrap_second", {last_v, last_h}, {5'd3, 4'd0});
        rd_word(9'd63, d);
        chk("wrap_data63", d, 16'h1234);
        rd_word(9'd48, d);
        chk("wrap_data48", d, 16'h5678);

        // Data with G=0 is discarded
        ins(8'h80); ins(8'h80);
        ins(8'h34);
        chk("g_off", {31'd0, graphic_on}, 32'd0);
        w0 = wr_cnt; e0 = err_cnt;
        dat_pair(8'hDE, 8'hAD);
        chk("g0_err", err_cnt - e0, 2);
        chk("g0_no_wr", wr_cnt - w0, 0);
        ins(SET_MODE_GRAPHIC);
        rd_word(9'd0, d);
        chk("g0_ram_kept", d, 16'hAA55);

        // Data while address pair incomplete: error, back to phase 0
        e0 = err_cnt;
        ins(8'h80);
        bus_wr(1'b1, 1'b0, 8'hAA);
        chk("addr_half_err", err_cnt - e0, 1);
        ins(8'h83); ins(8'h82);
        dat_pair(8'h9A, 8'hBC);
        chk("phase0_addr", {last_v, last_h}, {5'd3, 4'd2});
        rd_word(9'd50, d);
        chk("phase0_data", d, 16'h9ABC);
        chk("phase0_err_total", err_cnt - e0, 1);

        // Out-of-range vertical address blocks data
        e0 = err_cnt; w0 = wr_cnt;
        ins(8'hA0);
        chk("vbad_err", err_cnt - e0, 1);
        ins(8'h80);
        dat_pair(8'h01, 8'h02);
        chk("vbad_no_wr", wr_cnt - w0, 0);
        rd_word(9'd0, d);
        chk("vbad_ram_kept", d, 16'hAA55);
        ins(8'h80); ins(8'h80);
        dat_pair(8'h11, 8'h22);
        rd_word(9'd0, d);
        chk("vgood_data", d, 16'h1122);

        // Instruction between data bytes drops the held byte
        ins(8'h84); ins(8'h81);
        e0 = err_cnt;
        bus_wr(1'b1, 1'b0, 8'h33);
        ins(SET_MODE_GRAPHIC);
        chk("split_err", err_cnt - e0, 1);
        dat_pair(8'h44, 8'h55);
        chk("split_addr", {last_v, last_h}, {5'd4, 4'd1});
        rd_word(9'd65, d);
        chk("split_data", d, 16'h4455);

        // Standby in the extended set leaves the address alone
        ins(8'h85); ins(8'h82);
        e0 = err_cnt;
        ins(CLEAR_STANDBY);
        dat_pair(8'h66, 8'h77);
        chk("standby_addr", {last_v, last_h}, {5'd5, 4'd2});
        chk("standby_no_err", err_cnt - e0, 0);

        // Full frame, one address pair per row as the driver sends it
        e0 = err_cnt; w0 = wr_cnt; f0 = frame_cnt;
        for (int v = 0; v < 32; v++) begin
            ins(8'(8'h80 + v));
            ins(8'h80);
            for (int h = 0; h < 16; h++) begin
                d = img(v, h);
                dat_pair(d[15:8], d[7:0]);
            end
        end
        chk("frame_words", wr_cnt - w0, 512);
        chk("frame_done_once", frame_cnt - f0, 1);
        chk("frame_no_err", err_cnt - e0, 0);
        for (int a = 0; a < 512; a++) begin
            rd_word(9'(a), d);
            chk("frame_ram", d, img(a / 16, a % 16));
        end

        // Reset after a single data byte; the next pair lands at (0,0)
        ins(8'h87); ins(8'h83);
        bus_wr(1'b1, 1'b0, 8'hEE);
        do_reset();
        e0 = err_cnt; w0 = wr_cnt;
        ins(SET_MODE_GRAPHIC);
        ins(SET_MODE_GRAPHIC);
        dat_pair(8'hC3, 8'h3C);
        chk("rst_mid_wr", wr_cnt - w0, 1);
        chk("rst_mid_addr", {last_v, last_h}, 9'd0);
        chk("rst_mid_no_err", err_cnt - e0, 0);
        rd_word(9'd0, d);
        chk("rst_mid_data", d, 16'hC33C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
